// File: rtl/bin2bcd_loader_if.sv
// Handshake bundle between the bin2bcd loader and its requester/display.
// The requester drives start/bin; the loader drives everything else.
interface bin2bcd_loader_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic [7:0]       data;
  logic             load0;
  logic             load1;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, bin,
    input  data, load0, load1, busy, done, ovf
  );

  modport slave (
    input  start, bin,
    output data, load0, load1, busy, done, ovf
  );
endinterface

// File: rtl/bin2bcd_loader.sv
// Double-dabble binary-to-BCD converter, one bit per clock, that loads
// the result into the seven-segment display as two byte-wide digit pairs.
module bin2bcd_loader #(
  parameter int WIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  bin2bcd_loader_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(9999);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD0,
    LOAD1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [15:0]      bcd, bcd_n, adj;
  logic [CW-1:0]    cnt, cnt_n;
  logic             over;

  logic [7:0] data_q, data_n;
  logic       load0_q, load0_n;
  logic       load1_q, load1_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic       ovf_q, ovf_n;

  assign over = 32'(bus.bin) > 32'd9999;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    bcd_n   = bcd;
    cnt_n   = cnt;
    data_n  = 8'h00;
    load0_n = 1'b0;
    load1_n = 1'b0;
    done_n  = 1'b0;
    ovf_n   = ovf_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = CONV;
          sr_n    = over ? MAXV : bus.bin;
          ovf_n   = over;
          bcd_n   = '0;
          cnt_n   = '0;
        end
      end
      CONV: begin
        {bcd_n, sr_n} = {adj, sr} << 1;
        cnt_n = cnt + 1'b1;
        // Present the low pair from the final shifted value so it is
        // registered on the same edge as the last iteration.
        if (cnt == LAST) begin
          state_n = LOAD0;
          load0_n = 1'b1;
          data_n  = bcd_n[7:0];
        end
      end
      LOAD0: begin
        state_n = LOAD1;
        load1_n = 1'b1;
        data_n  = bcd[15:8];
      end
      LOAD1: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bcd     <= '0;
      cnt     <= '0;
      data_q  <= 8'h00;
      load0_q <= 1'b0;
      load1_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bcd     <= bcd_n;
      cnt     <= cnt_n;
      data_q  <= data_n;
      load0_q <= load0_n;
      load1_q <= load1_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.data  = data_q;
  assign bus.load0 = load0_q;
  assign bus.load1 = load1_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_bin2bcd_loader.sv
// Scoreboard bench for bin2bcd_loader: decimal reference model, directed
// boundary cases and a randomized sweep over the full input range.
module tb_bin2bcd_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_loader_if #(.WIDTH(14)) bus();
  bin2bcd_loader #(.WIDTH(14)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       ovf;
    int         t0;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ndone = 0;
  int          last_t0 = 0;
  logic [15:0] disp = 16'h0000;
  logic        got0 = 1'b0;
  logic        got1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports completion
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.load0 && bus.load1) chk("load_overlap", 1, 0);
      if (!bus.load0 && !bus.load1) chk("data_idle", bus.data, 0);
      if (bus.load0) begin
        if (sb.size() == 0) chk("spurious_load0", 1, 0);
        else begin
          chk("lo_data", bus.data, sb[0].lo);
          chk("load0_time", cyc - sb[0].t0, 14);
          chk("ovf", bus.ovf, sb[0].ovf);
          chk("busy_load0", bus.busy, 1);
          got0 = 1'b1;
        end
        disp[7:0] = bus.data;
      end
      if (bus.load1) begin
        if (sb.size() == 0) chk("spurious_load1", 1, 0);
        else begin
          chk("hi_data", bus.data, sb[0].hi);
          chk("load1_time", cyc - sb[0].t0, 15);
          got1 = 1'b1;
        end
        disp[15:8] = bus.data;
      end
      if (bus.done) begin
        ndone++;
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          chk("done_time", cyc - sb[0].t0, 16);
          chk("got_loads", {got0, got1}, 3);
          chk("busy_done", bus.busy, 0);
          void'(sb.pop_front());
          got0 = 1'b0;
          got1 = 1'b0;
        end
      end else if (sb.size() != 0 && cyc - sb[0].t0 > 16) begin
        chk("timeout", cyc - sb[0].t0, 16);
        void'(sb.pop_front());
        got0 = 1'b0;
        got1 = 1'b0;
      end
    end
  end

  task automatic issue(input int b);
    exp_t e;
    int   v;
    v = (b > 9999) ? 9999 : b;
    e.lo  = 8'(((v / 10) % 10) * 16 + v % 10);
    e.hi  = 8'((v / 1000) * 16 + (v / 100) % 10);
    e.ovf = (b > 9999);
    e.t0  = cyc + 1;
    sb.push_back(e);
    last_t0 = e.t0;
    bus.bin   = 14'(b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc < last_t0 + 16) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic conv(input int b);
    issue(b);
    wait_done();
    idle(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, bus.data, 0);
    chk({tag, "_load0"}, bus.load0, 0);
    chk({tag, "_load1"}, bus.load1, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
  endtask

  task automatic abort(input int b);
    logic [15:0] keep;
    keep = disp;
    issue(b);
    idle(4);
    rst = 1'b1;
    sb.delete();
    got0 = 1'b0;
    got1 = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    idle(20);
    chk("disp_kept", disp, keep);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.bin   = '0;
    rst       = 1'b1;
    idle(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    conv(1234);
    chk("disp_1234", disp, 16'h1234);
    conv(0);
    conv(9999);
    chk("disp_9999", disp, 16'h9999);
    conv(5);
    conv(1000);
    chk("disp_1000", disp, 16'h1000);

    issue(12000);
    wait_done();
    chk("ovf_held", bus.ovf, 1);
    issue(42);
    chk("ovf_cleared", bus.ovf, 0);
    wait_done();
    idle(2);

    n = ndone;
    issue(7);
    idle(3);
    bus.bin   = 14'd8888;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    idle(20);
    chk("one_done", ndone - n, 1);
    chk("disp_7", disp, 16'h0007);

    abort(16000);
    abort(4321);
    conv(4321);
    chk("disp_4321", disp, 16'h4321);

    issue(9);
    wait_done();
    issue(56);
    wait_done();
    idle(2);
    chk("disp_56", disp, 16'h0056);

    repeat (40) begin
      issue(int'($urandom_range(0, 16383)));
      wait_done();
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    idle(20);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin2bcd_loader.md
# bin2bcd_loader

Sequential binary-to-BCD converter that feeds the four-digit seven-segment display stage. It accepts a 14-bit binary value on a start strobe and converts it with the shift-and-add-3 (double-dabble) method, one bit per clock. It then writes the four BCD digits into the display's digit registers with two byte-wide load pulses: low pair first, then high pair. It sits directly upstream of the display block and drives that block's `data`, `load0` and `load1` inputs on the same `clk`.

## Interface
- `WIDTH`, 14, binary input width; legal range 4..14; also the number of conversion cycles.
- `clk`  in  1  system clock; the display block's `clk` is the same net.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `bin`  in  WIDTH  unsigned value; sampled on the edge that accepts `start`.
- `data`  out  8  digit pair to display: `{tens,units}` during `load0`, `{thousands,hundreds}` during `load1`; 0x00 otherwise.
- `load0`  out  1  one-cycle strobe; display latches units/tens.
- `load1`  out  1  one-cycle strobe; display latches hundreds/thousands.
- `busy`  out  1  high in CONV, LOAD0, LOAD1.
- `done`  out  1  one-cycle pulse after `load1` completes.
- `ovf`  out  1  last accepted `bin` exceeded 9999; held until the next accepted `start`.

## Operation
- States: IDLE, CONV, LOAD0, LOAD1.
- **IDLE → CONV:** on `start`=1.
  - Latch `bin` into the shift register.
  - If `bin` > 9999, substitute 9999 and set `ovf`=1; otherwise clear `ovf`.
  - Clear the 16-bit BCD accumulator and the bit counter.
- **CONV:** each cycle, for each of the 4 BCD nibbles, add 3 to any nibble ≥5. Then shift `{bcd,bin}` left 1.
  - After WIDTH iterations → LOAD0.
  - The counter is `$clog2(WIDTH+1)` bits and never wraps inside a conversion.
- **LOAD0:** `data`=`{bcd[7:4],bcd[3:0]}`, `load0`=1 → LOAD1.
- **LOAD1:** `data`=`{bcd[15:12],bcd[11:8]}`, `load1`=1 → IDLE, with `done`=1 registered for the following cycle.
- `start` while `busy` is ignored and is not queued.
- `start` in the same cycle as `done` is accepted, because the state is already IDLE.
- `load0` and `load1` are never high together, and each is high for exactly one cycle per conversion.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Reset values:** state IDLE; `data`=0x00, `load0`=0, `load1`=0, `busy`=0, `done`=0, `ovf`=0; accumulator 0.
- **Reset mid-operation:** abort immediately and emit no further load strobes.
  - Reset during CONV leaves the display registers untouched.
  - Reset during LOAD1 after LOAD0 has been issued leaves the display with new low digits and old high digits. This is accepted behaviour.
- Reset has priority over `start` in the same cycle.

## Timing
- Edge E0 samples `start`=1 in IDLE; `busy`=1 from E0.
- Conversion iterations occur on edges E1..E_WIDTH (E1..E14 for the default).
- `load0`/`data` are valid in the cycle after E_WIDTH; the display samples them at E_WIDTH+1.
- `load1`/`data` are valid after E_WIDTH+1; the display samples them at E_WIDTH+2.
- After E_WIDTH+2: `busy`=0, `done`=1 for one cycle.
- Start-to-done latency is WIDTH+3 cycles (17 for the default).
- Minimum start-to-start period is WIDTH+3 cycles.
- `ovf` is updated at E0 and is stable for the whole conversion.

## Test plan
- **Basic conversion:** reset 2 cycles, `start` with `bin`=1234.
  - `load0` with `data`=0x34 in cycle 15 after `start`.
  - `load1` with `data`=0x12 in cycle 16.
  - `done` in cycle 17, `ovf`=0.
  - A display model shows 1,2,3,4.
- **Boundary values:**
  - `bin`=0 → 0x00, then 0x00.
  - `bin`=9999 → 0x99, then 0x99, `ovf`=0.
  - `bin`=5 → 0x05, then 0x00.
  - `bin`=1000 → 0x00, then 0x10.
- **Overflow:**
  - `bin`=12000 → 0x99, 0x99, `ovf`=1.
  - A following `start` with `bin`=42 → 0x42, 0x00, `ovf` cleared at that start edge.
- **Busy rejection:** `start` with `bin`=7 accepted; second `start` with `bin`=8888 at cycle 5 → output is 0x07/0x00 only, with exactly one `done`.
- **Reset mid-op:**
  - `rst` at cycle 6 of a 4321 conversion → no `load0`/`load1`, all outputs at reset values, display model keeps its prior digits.
  - A subsequent `start` with `bin`=4321 → 0x21, 0x43.
- **Back-to-back:** `start` asserted in the `done` cycle with `bin`=56 → accepted; 0x56, 0x00 after a further 17 cycles. Randomized sweep of 0..16383 checked against a reference decimal model.
